// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: ALU opcodes, arbiter FSM states and opcode classification.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    NOOP,
    RECOVER,
    RESP
  } arb_state_t;

  // Ops that make the ALU compute and raise done; no_op and rst_op do not.
  function automatic logic is_alu_op(operation_t op);
    return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
  endfunction

endpackage

// File: rtl/tinyalu_rr_pick.sv
// Round-robin picker: first requesting index after last_grant, wrapping modulo NUM_REQ.
module tinyalu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_grant) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin front end sharing one TinyALU among NUM_REQ requesters; sole driver of the ALU pins.
module tinyalu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_A,
  input  logic [8*NUM_REQ-1:0] req_B,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_result,
  output logic                 rsp_error,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  output logic                 alu_reset_n,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rcnt_q, rcnt_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [15:0]          result_q, result_d;
  logic                 error_q, error_d;

  logic [NUM_REQ-1:0]   req_ready_d, rsp_valid_d;
  logic [15:0]          rsp_result_d;
  logic                 rsp_error_d;
  logic [7:0]           alu_A_d, alu_B_d;
  logic [2:0]           alu_op_d;
  logic                 alu_start_d, alu_reset_n_d;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic [7:0]           sel_a, sel_b;
  logic [2:0]           sel_op;
  operation_t           op_sel;

  tinyalu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .idx        (pick_idx)
  );

  // Operand mux keyed by the one-hot grant.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_a  = req_A[8*i +: 8];
        sel_b  = req_B[8*i +: 8];
        sel_op = req_op[3*i +: 3];
      end
    end
  end

  assign op_sel = operation_t'(sel_op);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rcnt_d        = rcnt_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    result_d      = result_q;
    error_d       = error_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_result_d  = '0;
    rsp_error_d   = 1'b0;
    alu_A_d       = alu_A;
    alu_B_d       = alu_B;
    alu_op_d      = alu_op;
    alu_start_d   = alu_start;
    alu_reset_n_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready_d  = pick_grant;
          last_grant_d = pick_idx;
          owner_d      = pick_idx;
          cnt_d        = '0;
          if (is_alu_op(op_sel) || op_sel == no_op) begin
            alu_A_d     = sel_a;
            alu_B_d     = sel_b;
            alu_op_d    = sel_op;
            alu_start_d = 1'b1;
            state_d     = (op_sel == no_op) ? NOOP : ISSUE;
          end else begin
            // rst_op and undefined codes are answered without touching the ALU.
            result_d = '0;
            error_d  = 1'b1;
            state_d  = RESP;
          end
        end
      end
      ISSUE: begin
        if (alu_done) begin
          alu_start_d = 1'b0;
          result_d    = alu_result;
          error_d     = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          alu_start_d   = 1'b0;
          alu_reset_n_d = 1'b0;
          rcnt_d        = 1'b0;
          result_d      = '0;
          error_d       = 1'b1;
          state_d       = RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      NOOP: begin
        alu_start_d = 1'b0;
        result_d    = '0;
        error_d     = 1'b0;
        state_d     = RESP;
      end
      RECOVER: begin
        // Second low cycle of the ALU reset, then report the abort.
        if (!rcnt_q) begin
          alu_reset_n_d = 1'b0;
          rcnt_d        = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_d[owner_q] = 1'b1;
        rsp_result_d         = result_q;
        rsp_error_d          = error_q;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rcnt_q       <= 1'b0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_error    <= 1'b0;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_op       <= '0;
      alu_start    <= 1'b0;
      alu_reset_n  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      req_ready    <= req_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_result   <= rsp_result_d;
      rsp_error    <= rsp_error_d;
      alu_A        <= alu_A_d;
      alu_B        <= alu_B_d;
      alu_op       <= alu_op_d;
      alu_start    <= alu_start_d;
      alu_reset_n  <= alu_reset_n_d;
    end
  end

  // Result payload only; no reset needed.
  always_ff @(posedge clk) begin
    result_q <= result_d;
    error_q  <= error_d;
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter with a behavioural TinyALU (add/and/xor 1 cycle, mul 3 cycles).
module tb_tinyalu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 15;
  localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_XOR = 3'b011,
                         OP_MUL = 3'b100, OP_RST = 3'b111, OP_BAD = 3'b101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_A, req_B;
  logic [11:0] req_op;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_result;
  logic        rsp_error;
  logic [7:0]  alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_start, alu_reset_n;
  logic        alu_done   = 1'b0;
  logic [15:0] alu_result = '0;

  always #5 clk = ~clk;

  tinyalu_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_start(alu_start), .alu_reset_n(alu_reset_n),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  // Behavioural TinyALU, updated on the falling edge.
  int k = 0;
  bit hang = 1'b0;
  always @(negedge clk) begin
    if (!alu_reset_n) begin
      k = 0; alu_done = 1'b0; alu_result = '0;
    end else if (alu_done) begin
      alu_done = 1'b0; k = 0;
    end else if (alu_start && !hang) begin
      k++;
      if (k == ((alu_op == OP_MUL) ? 4 : 2)) begin
        alu_done = 1'b1;
        case (alu_op)
          3'b001:  alu_result = {8'h00, alu_A} + {8'h00, alu_B};
          3'b010:  alu_result = {8'h00, alu_A & alu_B};
          3'b011:  alu_result = {8'h00, alu_A ^ alu_B};
          3'b100:  alu_result = alu_A * alu_B;
          default: alu_result = '0;
        endcase
      end
    end else begin
      k = 0;
    end
  end

  // Event log sampled just after each rising edge.
  int cyc = 0, acc_cnt = 0, rsp_cnt = 0, start_cnt = 0, rstlow_cnt = 0, multi_hot = 0;
  int last_acc_cyc = 0, last_rsp_cyc = 0;
  logic [3:0]  last_acc_vec = '0, last_rsp_vec = '0;
  logic [15:0] last_rsp_res = '0;
  logic        last_rsp_err = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (alu_start) start_cnt++;
    if (!alu_reset_n) rstlow_cnt++;
    if (|req_ready) begin
      acc_cnt++; last_acc_vec = req_ready; last_acc_cyc = cyc;
      if (!$onehot(req_ready)) multi_hot++;
    end
    if (|rsp_valid) begin
      rsp_cnt++; last_rsp_vec = rsp_valid; last_rsp_cyc = cyc;
      last_rsp_res = rsp_result; last_rsp_err = rsp_error;
      if (!$onehot(rsp_valid)) multi_hot++;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_acc(input int base);
    int n = 0;
    while (acc_cnt == base && n < 60) begin @(negedge clk); n++; end
    if (acc_cnt == base) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int base);
    int n = 0;
    while (rsp_cnt == base && n < 60) begin @(negedge clk); n++; end
    if (rsp_cnt == base) check("response_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int a0, r0;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    req_A[8*r +: 8] = a;
    req_B[8*r +: 8] = b;
    req_op[3*r +: 3] = op;
    req_valid[r] = 1'b1;
    wait_acc(a0);
    req_valid[r] = 1'b0;
    wait_rsp(r0);
  endtask

  int s0, rl0, r0, a0;
  logic [3:0]  exp_vec [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [15:0] exp_xor [4] = '{16'h00F0, 16'h00CC, 16'h00AA, 16'h000F};

  initial begin
    reset_n = 1'b0; req_valid = '0; req_A = '0; req_B = '0; req_op = '0;
    repeat (3) @(negedge clk);
    check("rst_alu_start", alu_start, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_alu_reset_n", alu_reset_n, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("alu_reset_n_release", alu_reset_n, 1);

    // Single add from requester 0
    s0 = start_cnt;
    do_req(0, 8'h12, 8'h34, OP_ADD);
    check("add_vec", last_rsp_vec, 4'b0001);
    check("add_result", last_rsp_res, 16'h0046);
    check("add_error", last_rsp_err, 0);
    check("add_latency", last_rsp_cyc - last_acc_cyc, 3);
    check("add_start_cycles", start_cnt - s0, 2);
    check("add_alu_A", alu_A, 8'h12);
    check("add_alu_B", alu_B, 8'h34);

    // Mul from requester 1
    s0 = start_cnt;
    do_req(1, 8'hFF, 8'hFF, OP_MUL);
    check("mul_vec", last_rsp_vec, 4'b0010);
    check("mul_result", last_rsp_res, 16'hFE01);
    check("mul_error", last_rsp_err, 0);
    check("mul_latency", last_rsp_cyc - last_acc_cyc, 5);
    check("mul_start_cycles", start_cnt - s0, 4);

    // Fairness: all requesters held valid with xor
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; @(negedge clk);
    req_A = {8'hF0, 8'h55, 8'h33, 8'h0F};
    req_B = {4{8'hFF}};
    req_op = {4{OP_XOR}};
    r0 = rsp_cnt;
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      wait_rsp(r0 + i);
      check($sformatf("rr_acc_vec%0d", i), last_acc_vec, exp_vec[i % 4]);
      check($sformatf("rr_rsp_vec%0d", i), last_rsp_vec, exp_vec[i % 4]);
      check($sformatf("rr_result%0d", i), last_rsp_res, exp_xor[i % 4]);
    end
    req_valid = '0;
    repeat (6) @(negedge clk);

    // no_op, rst_op and an undefined opcode
    s0 = start_cnt;
    do_req(2, 8'h01, 8'h02, OP_NOP);
    check("nop_vec", last_rsp_vec, 4'b0100);
    check("nop_latency", last_rsp_cyc - last_acc_cyc, 2);
    check("nop_error", last_rsp_err, 0);
    check("nop_result", last_rsp_res, 0);
    check("nop_start_cycles", start_cnt - s0, 1);
    s0 = start_cnt;
    do_req(2, 8'h03, 8'h04, OP_RST);
    check("rstop_vec", last_rsp_vec, 4'b0100);
    check("rstop_latency", last_rsp_cyc - last_acc_cyc, 1);
    check("rstop_error", last_rsp_err, 1);
    check("rstop_result", last_rsp_res, 0);
    check("rstop_start_cycles", start_cnt - s0, 0);
    check("rstop_alu_op_held", alu_op, OP_NOP);
    do_req(1, 8'h05, 8'h06, OP_BAD);
    check("badop_vec", last_rsp_vec, 4'b0010);
    check("badop_latency", last_rsp_cyc - last_acc_cyc, 1);
    check("badop_error", last_rsp_err, 1);

    // Timeout: ALU never answers
    hang = 1'b1;
    s0 = start_cnt; rl0 = rstlow_cnt;
    do_req(3, 8'h01, 8'h02, OP_ADD);
    check("to_vec", last_rsp_vec, 4'b1000);
    check("to_start_cycles", start_cnt - s0, 15);
    check("to_alu_reset_low", rstlow_cnt - rl0, 2);
    check("to_error", last_rsp_err, 1);
    check("to_result", last_rsp_res, 0);
    check("to_latency", last_rsp_cyc - last_acc_cyc, 18);
    hang = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during a mul, then priority restarts at requester 0
    req_A[15:8] = 8'h03; req_B[15:8] = 8'h04; req_op[5:3] = OP_MUL;
    a0 = acc_cnt;
    req_valid[1] = 1'b1;
    wait_acc(a0);
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_alu_start", alu_start, 0);
    check("midrst_alu_reset_n", alu_reset_n, 0);
    check("midrst_alu_A", alu_A, 0);
    check("midrst_alu_op", alu_op, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    reset_n = 1'b1;
    @(negedge clk);
    req_A[7:0] = 8'h05;   req_B[7:0] = 8'h06;   req_op[2:0] = OP_ADD;
    req_A[31:24] = 8'h07; req_B[31:24] = 8'h08; req_op[11:9] = OP_ADD;
    a0 = acc_cnt; r0 = rsp_cnt;
    req_valid = 4'b1001;
    wait_acc(a0);
    check("postrst_first_grant", last_acc_vec, 4'b0001);
    req_valid[0] = 1'b0;
    wait_rsp(r0);
    check("postrst_rsp0_vec", last_rsp_vec, 4'b0001);
    check("postrst_rsp0_result", last_rsp_res, 16'h000B);
    a0 = acc_cnt; r0 = rsp_cnt;
    wait_acc(a0);
    req_valid[3] = 1'b0;
    wait_rsp(r0);
    check("postrst_rsp3_vec", last_rsp_vec, 4'b1000);
    check("postrst_rsp3_result", last_rsp_res, 16'h000F);
    req_valid = '0;
    repeat (3) @(negedge clk);

    check("onehot_pulses", multi_hot, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
